// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types, constants and scaling helper for the WS2812 frame controller
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SCALE,
        SEND,
        LATCH
    } ctrl_state_t;

    localparam int BYTES_PER_LED = 3;

    // Brightness scaling: (value * (bri + 1)) >> 8 on a 16-bit product, so bri=255 is identity.
    function automatic logic [7:0] scale8(input logic [7:0] value, input logic [7:0] bri);
        return 8'((({8'd0, value} * ({8'd0, bri} + 16'd1))) >> 8);
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// rtl/ws2812_pixel_ram.sv - dual-bank pixel byte store, one write port and one synchronous read port
module ws2812_pixel_ram #(
    parameter int DEPTH  = 24,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2][DEPTH];

    // Host write; addresses beyond the frame are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Registered read, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - double-buffered frame scheduler feeding the WS2812 byte serializer
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = $clog2(NUM_LEDS * BYTES_PER_LED)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        brightness,
    input  logic              show,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        ser_data,
    output logic              ser_latch,
    input  logic              ser_next
);

    localparam int                NUM_BYTES = NUM_LEDS * BYTES_PER_LED;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    ctrl_state_t       state, state_next;
    logic              front, front_next;
    logic [7:0]        bri_q, bri_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic              busy_next;
    logic              done_next;
    logic [7:0]        data_next;
    logic              latch_next;
    logic              show_pending, pend_next;
    logic [7:0]        ram_q;

    // Host always writes the bank not being streamed; the streamed bank is read at the frame address.
    ws2812_pixel_ram #(
        .DEPTH  (NUM_BYTES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (~front),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == READ),
        .rd_bank (front),
        .rd_addr (addr),
        .rd_data (ram_q)
    );

    // Next-state and next-register logic; a frame start swaps banks and samples brightness.
    always_comb begin
        state_next = state;
        front_next = front;
        bri_next   = bri_q;
        addr_next  = addr;
        busy_next  = busy;
        done_next  = 1'b0;
        data_next  = ser_data;
        latch_next = ser_latch;
        pend_next  = show_pending | (show & busy);

        case (state)
            IDLE: begin
                latch_next = 1'b1;
                if (show || show_pending) begin
                    pend_next  = 1'b0;
                    front_next = ~front;
                    bri_next   = brightness;
                    addr_next  = '0;
                    busy_next  = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                state_next = SCALE;
            end
            SCALE: begin
                data_next  = scale8(ram_q, bri_q);
                latch_next = 1'b0;
                state_next = SEND;
            end
            SEND: begin
                if (ser_next) begin
                    if (addr == LAST_ADDR) begin
                        latch_next = 1'b1;
                        state_next = LATCH;
                    end else begin
                        addr_next  = addr + 1'b1;
                        state_next = READ;
                    end
                end
            end
            LATCH: begin
                latch_next = 1'b1;
                if (ser_next) begin
                    done_next = 1'b1;
                    // A show arriving with the latch accept is served right away.
                    if (show_pending || show) begin
                        pend_next  = 1'b0;
                        front_next = ~front;
                        bri_next   = brightness;
                        addr_next  = '0;
                        state_next = READ;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; reset forces the serializer into a latch period.
    always_ff @(posedge clk) begin
        if (reset) begin
            front        <= 1'b0;
            bri_q        <= 8'd0;
            addr         <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            ser_data     <= 8'd0;
            ser_latch    <= 1'b1;
            show_pending <= 1'b0;
        end else begin
            front        <= front_next;
            bri_q        <= bri_next;
            addr         <= addr_next;
            busy         <= busy_next;
            frame_done   <= done_next;
            ser_data     <= data_next;
            ser_latch    <= latch_next;
            show_pending <= pend_next;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - scoreboard bench for ws2812_frame_ctrl with a serializer model
module tb_ws2812_frame_ctrl;

    localparam int NUM_LEDS = 2;
    localparam int NB       = NUM_LEDS * 3;
    localparam int AW       = $clog2(NB);

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [7:0]    wr_data    = 8'd0;
    logic [7:0]    brightness = 8'd0;
    logic          show       = 1'b0;
    logic          ser_next   = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [7:0]    ser_data;
    logic          ser_latch;

    ws2812_frame_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .show       (show),
        .busy       (busy),
        .frame_done (frame_done),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .ser_next   (ser_next)
    );

    initial forever #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: two byte banks, which one is displayed, and a queue of expected serializer items.
    int mem [2][NB];
    int model_front   = 0;
    bit model_busy    = 1'b0;
    bit model_pend    = 1'b0;
    int fd_exp        = 0;
    int exp_q [$];            // byte value, or -1 for the latch request
    int fd_count      = 0;
    int busy_falls    = 0;
    int samp_in_frame = 0;
    bit inject_next   = 1'b0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic void start_frame();
        model_front = 1 - model_front;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back((mem[model_front][i] * (int'(brightness) + 1)) / 256);
        end
        exp_q.push_back(-1);
        model_busy    = 1'b1;
        samp_in_frame = 0;
    endfunction

    function automatic void sample_item();
        int e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_sample: got latch=%0d data=0x%02h expected no item", ser_latch, ser_data);
        end else begin
            e = exp_q.pop_front();
            if (e < 0) begin
                check("latch_request", int'(ser_latch), 1);
                fd_exp++;
                if (model_pend) begin
                    model_pend = 1'b0;
                    start_frame();
                end else begin
                    model_busy = 1'b0;
                end
            end else begin
                check("latch_low_on_byte", int'(ser_latch), 0);
                check("ser_byte", int'(ser_data), e);
                samp_in_frame++;
            end
        end
    endfunction

    // Serializer model: samples on the falling edge, pulses ser_next the next cycle, >= 4 cycles apart.
    initial begin : serializer
        int mode;
        int cnt;
        bit pulse;
        bit do_sample;
        mode  = 0;
        cnt   = 0;
        pulse = 1'b0;
        forever begin
            @(negedge clk);
            ser_next = 1'b0;
            if (reset) begin
                mode  = 0;
                pulse = 1'b0;
            end else begin
                if (pulse || inject_next) begin
                    ser_next    = 1'b1;
                    pulse       = 1'b0;
                    inject_next = 1'b0;
                end
                do_sample = 1'b0;
                if (mode == 0) begin
                    if (!ser_latch) do_sample = 1'b1;
                end else begin
                    cnt--;
                    if (cnt == 0) do_sample = 1'b1;
                end
                if (do_sample) begin
                    if (ser_latch) mode = 0;
                    else begin
                        mode = 1;
                        cnt  = 4 + int'($urandom_range(0, 3));
                    end
                    sample_item();
                    pulse = 1'b1;
                end
            end
        end
    end

    // Flag monitor: counts frame_done pulses and busy falling edges.
    initial begin : flag_mon
        bit prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) fd_count++;
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = 8'(d);
        if (a < NB) mem[1 - model_front][a] = d & 255;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_frame(input bit rnd, input int base);
        for (int i = 0; i < NB; i++) begin
            host_write(i, rnd ? int'($urandom_range(0, 255)) : base * (i + 1));
        end
    endtask

    task automatic do_show();
        bit was_idle;
        was_idle = !model_busy;
        show = 1'b1;
        if (was_idle) start_frame();
        else model_pend = 1'b1;
        tick();
        show = 1'b0;
        if (was_idle) check("busy_after_show", int'(busy), 1);
    endtask

    task automatic write_and_show(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = 8'(d);
        show    = 1'b1;
        mem[1 - model_front][a] = d & 255;
        start_frame();
        tick();
        wr_en = 1'b0;
        show  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((model_busy || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("frame_timeout", int'(n < 3000), 1);
        repeat (3) tick();
        check("busy_idle", int'(busy), 0);
        check("latch_idle", int'(ser_latch), 1);
        check("frame_done_count", fd_count, fd_exp);
    endtask

    initial begin : stimulus
        int fd0;
        int bf0;
        int n;

        repeat (3) tick();
        check("reset_ser_latch", int'(ser_latch), 1);
        check("reset_ser_data", int'(ser_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        tick();

        // Stray serializer pulse in IDLE must be ignored.
        inject_next = 1'b1;
        repeat (6) tick();
        check("idle_pulse_frame_done", fd_count, 0);
        check("idle_pulse_busy", int'(busy), 0);

        // Full brightness, plus an out-of-range write that must be dropped.
        for (int i = 0; i < NB; i++) host_write(i, 17 * (i + 1));
        host_write(6, 8'hEE);
        brightness = 8'd255;
        do_show();
        wait_idle();

        // Half brightness on the same data.
        for (int i = 0; i < NB; i++) host_write(i, 17 * (i + 1));
        brightness = 8'd127;
        do_show();
        wait_idle();

        // Zero brightness blanks full-scale bytes.
        write_frame(1'b0, 0);
        for (int i = 0; i < NB; i++) host_write(i, 255);
        brightness = 8'd0;
        do_show();
        wait_idle();

        // Double buffer: write B while A streams, show B, then show A again without rewriting.
        brightness = 8'd255;
        write_frame(1'b1, 0);
        do_show();
        write_frame(1'b1, 0);
        wait_idle();
        do_show();
        wait_idle();
        do_show();
        wait_idle();

        // Three shows during a frame collapse into exactly one back-to-back frame.
        fd0 = fd_count;
        bf0 = busy_falls;
        brightness = 8'($urandom_range(0, 255));
        write_frame(1'b1, 0);
        do_show();
        write_frame(1'b1, 0);
        for (int j = 0; j < 3; j++) begin
            repeat (2) tick();
            do_show();
        end
        wait_idle();
        check("pending_frame_done_pulses", fd_count - fd0, 2);
        check("pending_busy_falls", busy_falls - bf0, 1);

        // Write and show in the same IDLE cycle: the write lands before the swap.
        write_frame(1'b1, 0);
        write_and_show(2, 8'h5A);
        wait_idle();

        // Brightness change mid-frame has no effect on the running frame.
        write_frame(1'b1, 0);
        brightness = 8'd200;
        do_show();
        brightness = 8'd3;
        wait_idle();

        // Reset while streaming byte 3.
        write_frame(1'b1, 0);
        brightness = 8'd255;
        do_show();
        n = 0;
        while (samp_in_frame < 3 && n < 500) begin
            tick();
            n++;
        end
        check("reach_byte3_timeout", int'(n < 500), 1);
        reset = 1'b1;
        tick();
        check("midreset_ser_latch", int'(ser_latch), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ser_data", int'(ser_data), 0);
        reset = 1'b0;
        exp_q.delete();
        model_busy  = 1'b0;
        model_pend  = 1'b0;
        model_front = 0;
        tick();
        write_frame(1'b1, 0);
        do_show();
        wait_idle();

        // Randomised frames.
        for (int k = 0; k < 6; k++) begin
            brightness = 8'($urandom_range(0, 255));
            write_frame(1'b1, 0);
            do_show();
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
